// File: rtl/seq_feeder_if.sv
// Memory-read and systolic-array bus of the sequence feeder.
// master = feeder side, slave = memories plus array side.
interface seq_feeder_if #(
   parameter int unsigned BP_WIDTH   = 2,
   parameter int unsigned ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] s_addr_o;
   logic [ADDR_WIDTH-1:0] t_addr_o;
   logic [BP_WIDTH-1:0]   s_rdata_i;
   logic [BP_WIDTH-1:0]   t_rdata_i;
   logic                  array_busy_i;
   logic                  new_seq_o;
   logic                  s_update_o;
   logic                  ack_o;
   logic                  valid_o;
   logic [BP_WIDTH-1:0]   S_o;
   logic [BP_WIDTH-1:0]   T_o;

   modport master (
      output s_addr_o, t_addr_o, new_seq_o, s_update_o, ack_o, valid_o, S_o, T_o,
      input  s_rdata_i, t_rdata_i, array_busy_i
   );

   modport slave (
      input  s_addr_o, t_addr_o, new_seq_o, s_update_o, ack_o, valid_o, S_o, T_o,
      output s_rdata_i, t_rdata_i, array_busy_i
   );
endinterface

// File: rtl/seq_feeder.sv
// Feeds one S/T pair into an N-PE systolic array: S in reversed N-symbol chunks, T streamed per chunk.
// Optional FEEDER_PERF_EN adds stall_cnt_o, a saturating count of busy cycles in WAIT_ARR.
module seq_feeder #(
   parameter int unsigned N          = 4,
   parameter int unsigned BP_WIDTH   = 2,
   parameter int unsigned LEN_WIDTH  = 12,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [LEN_WIDTH-1:0] s_len_i,
   input  logic [LEN_WIDTH-1:0] t_len_i,
   seq_feeder_if.master         bus,
   output logic                 active_o,
   output logic                 done_o,
   output logic                 err_o
`ifdef FEEDER_PERF_EN
   ,
   output logic [15:0]          stall_cnt_o
`endif
);

   // Wide enough to hold a padded symbol index (< s_len + N) without wrapping.
   localparam int unsigned IW = LEN_WIDTH + $clog2(N) + 1;

   typedef enum logic [2:0] {
      StIdle, StNewSeq, StLoadS, StUpdate, StGap, StStreamT, StWaitArr, StDone
   } state_t;

   state_t               r_state, w_state_d;
   logic [LEN_WIDTH-1:0] r_k, w_k_d;
   logic [IW-1:0]        r_base, w_base_d;
   logic [LEN_WIDTH-1:0] r_s_len, w_s_len_d;
   logic [LEN_WIDTH-1:0] r_t_len, w_t_len_d;
   logic                 r_err, w_err_d;
   logic [IW-1:0]        w_s_idx;
   logic                 w_last_chunk;

   // r_base holds j*N, so j+1 < C is equivalent to j*N + N < s_len.
   assign w_s_idx      = r_base + IW'(N - 1) - IW'(r_k);
   assign w_last_chunk = (r_base + IW'(N)) >= IW'(r_s_len);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_state <= StIdle;
         r_k     <= '0;
         r_base  <= '0;
         r_s_len <= '0;
         r_t_len <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_k     <= w_k_d;
         r_base  <= w_base_d;
         r_s_len <= w_s_len_d;
         r_t_len <= w_t_len_d;
         r_err   <= w_err_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_k_d     = r_k;
      w_base_d  = r_base;
      w_s_len_d = r_s_len;
      w_t_len_d = r_t_len;
      w_err_d   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start_i) begin
               if (s_len_i == '0 || t_len_i == '0) begin
                  w_err_d = 1'b1;
               end else begin
                  w_state_d = StNewSeq;
                  w_s_len_d = s_len_i;
                  w_t_len_d = t_len_i;
                  w_base_d  = '0;
               end
            end
         end
         StNewSeq: begin
            w_state_d = StLoadS;
            w_k_d     = '0;
         end
         StLoadS: begin
            if (r_k == LEN_WIDTH'(N - 1)) begin
               w_state_d = StUpdate;
               w_k_d     = '0;
            end else begin
               w_k_d = r_k + LEN_WIDTH'(1);
            end
         end
         StUpdate: w_state_d = StGap;
         StGap: begin
            w_state_d = StStreamT;
            w_k_d     = '0;
         end
         StStreamT: begin
            if (r_k == r_t_len - LEN_WIDTH'(1)) begin
               w_state_d = StWaitArr;
               w_k_d     = '0;
            end else begin
               w_k_d = r_k + LEN_WIDTH'(1);
            end
         end
         StWaitArr: begin
            // r_k only marks "past the first cycle" here, so the minimum stay is two cycles.
            w_k_d = LEN_WIDTH'(1);
            if (r_k != '0 && !bus.array_busy_i) begin
               if (w_last_chunk) begin
                  w_state_d = StDone;
               end else begin
                  w_state_d = StLoadS;
                  w_k_d     = '0;
                  w_base_d  = r_base + IW'(N);
               end
            end
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
      if (abort_i) begin
         w_state_d = StIdle;
         w_k_d     = '0;
         w_err_d   = 1'b0;
      end
   end

   // Addresses lead their data by one cycle; NEWSEQ, GAP and WAIT_ARR prefetch the first symbol.
   always_comb begin
      bus.new_seq_o  = (r_state == StNewSeq);
      bus.s_update_o = (r_state == StUpdate);
      bus.ack_o      = (r_state == StLoadS) || (r_state == StGap) ||
                       (r_state == StStreamT) || (r_state == StWaitArr);
      bus.valid_o    = (r_state == StStreamT);
      active_o       = (r_state != StIdle);
      done_o         = (r_state == StDone);
      err_o          = r_err;
      bus.s_addr_o   = '0;
      bus.t_addr_o   = '0;
      bus.S_o        = '0;
      bus.T_o        = '0;
      case (r_state)
         StNewSeq:  bus.s_addr_o = ADDR_WIDTH'(r_base + IW'(N - 1));
         StLoadS: begin
            bus.s_addr_o = ADDR_WIDTH'(w_s_idx - IW'(1));
            if (w_s_idx < IW'(r_s_len)) bus.S_o = bus.s_rdata_i;
         end
         StGap:     bus.t_addr_o = '0;
         StStreamT: begin
            bus.t_addr_o = ADDR_WIDTH'(r_k + LEN_WIDTH'(1));
            bus.T_o      = bus.t_rdata_i;
         end
         StWaitArr: bus.s_addr_o = ADDR_WIDTH'(r_base + IW'(2 * N - 1));
         default:   bus.s_addr_o = '0;
      endcase
   end

`ifdef FEEDER_PERF_EN
   logic        w_accept;
   logic [15:0] r_stall;

   assign w_accept = (r_state == StIdle) && start_i && !abort_i &&
                     (s_len_i != '0) && (t_len_i != '0);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_stall <= '0;
      end else if (w_accept) begin
         r_stall <= '0;
      end else if (r_state == StWaitArr && bus.array_busy_i && r_stall != 16'hFFFF) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   assign stall_cnt_o = r_stall;
`endif

endmodule

// File: tb/tb_seq_feeder.sv
// Self-checking bench for seq_feeder: per-cycle outputs compared against a timeline model
// built from the feeder's phase rules, with random sequence memories and lengths.
module tb_seq_feeder;
   localparam int unsigned N   = 4;
   localparam int unsigned BPW = 2;
   localparam int unsigned LW  = 12;
   localparam int unsigned AW  = 12;

   typedef struct packed {
      logic           active;
      logic           new_seq;
      logic           s_update;
      logic           ack;
      logic           valid;
      logic           done;
      logic           err;
      logic [BPW-1:0] s;
      logic [BPW-1:0] t;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic          abort_i;
   logic [LW-1:0] s_len_i;
   logic [LW-1:0] t_len_i;
   logic          active_o;
   logic          done_o;
   logic          err_o;
`ifdef FEEDER_PERF_EN
   logic [15:0]   stall_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   logic [BPW-1:0] smem [0:(1<<AW)-1];
   logic [BPW-1:0] tmem [0:(1<<AW)-1];

   seq_feeder_if #(.BP_WIDTH(BPW), .ADDR_WIDTH(AW)) bus ();

   seq_feeder #(.N(N), .BP_WIDTH(BPW), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .s_len_i     (s_len_i),
      .t_len_i     (t_len_i),
      .bus         (bus),
      .active_o    (active_o),
      .done_o      (done_o),
      .err_o       (err_o)
`ifdef FEEDER_PERF_EN
      ,
      .stall_cnt_o (stall_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read memories: data appears the cycle after the address.
   always @(posedge clk) begin
      bus.s_rdata_i <= smem[bus.s_addr_o];
      bus.t_rdata_i <= tmem[bus.t_addr_o];
   end

   function automatic obs_t sample();
      return obs_t'({active_o, bus.new_seq_o, bus.s_update_o, bus.ack_o, bus.valid_o,
                     done_o, err_o, bus.S_o, bus.T_o});
   endfunction

   function automatic obs_t mk(bit a, bit ns, bit su, bit ak, bit v, bit d, bit e,
                               logic [BPW-1:0] s, logic [BPW-1:0] t);
      return obs_t'({a, ns, su, ak, v, d, e, s, t});
   endfunction

   task automatic check(input string tag, input obs_t o, input obs_t e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic check_stall(input string tag, input int exp_cnt);
`ifdef FEEDER_PERF_EN
      checks++;
      assert (stall_cnt_o === 16'(exp_cnt)) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, stall_cnt_o, exp_cnt);
      end
`else
      if (exp_cnt < 0) $display("unused %s", tag);
`endif
   endtask

   // Called at a negedge: requests the pair, then checks one timeline entry per cycle.
   // stop > 0 returns after that many entries (still at a negedge).
   task automatic run_pair(input string tag, input int slen, input int tlen, input int b,
                           input int stop);
      obs_t exq[$];
      bit   bsq[$];
      int   c;
      int   idx;
      int   w;
      for (int i = 0; i < 64; i++) begin
         smem[i] = BPW'($urandom);
         tmem[i] = BPW'($urandom);
      end
      c = (slen + N - 1) / N;
      exq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0)); bsq.push_back(0);
      for (int ch = 0; ch < c; ch++) begin
         for (int k = 0; k < N; k++) begin
            idx = ch * N + N - 1 - k;
            exq.push_back(mk(1, 0, 0, 1, 0, 0, 0, (idx < slen) ? smem[idx] : '0, 0));
            bsq.push_back(0);
         end
         exq.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0)); bsq.push_back(0);
         exq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0)); bsq.push_back(0);
         for (int i = 0; i < tlen; i++) begin
            exq.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, tmem[i])); bsq.push_back(0);
         end
         w = (b + 1 > 2) ? b + 1 : 2;
         for (int m = 0; m < w; m++) begin
            exq.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0)); bsq.push_back(m < b);
         end
      end
      exq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0)); bsq.push_back(0);
      exq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); bsq.push_back(0);

      s_len_i = LW'(slen);
      t_len_i = LW'(tlen);
      start_i = 1'b1;
      for (int i = 0; i < exq.size(); i++) begin
         @(negedge clk);
         start_i = 1'b0;
         bus.array_busy_i = bsq[i];
         check($sformatf("%s[%0d]", tag, i), sample(), exq[i]);
         if (i + 1 == stop) break;
      end
      bus.array_busy_i = 1'b0;
      if (stop <= 0) check_stall({tag, "_stall"}, b * c);
   endtask

   initial begin
      obs_t zero;
      int   sl;
      int   tl;
      int   bb;
      zero = '0;
      reset_i = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      s_len_i = '0;
      t_len_i = '0;
      bus.array_busy_i = 1'b0;
      #12;
      check("reset", sample(), zero);
      @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      check("idle", sample(), zero);

      run_pair("basic", 4, 3, 0, 0);
      run_pair("twochunk", 6, 5, 0, 0);
      run_pair("busy10", 4, 3, 10, 0);

      for (int r = 0; r < 6; r++) begin
         sl = int'($urandom_range(1, 13));
         tl = int'($urandom_range(1, 8));
         bb = int'($urandom_range(0, 4));
         run_pair($sformatf("rand%0d", r), sl, tl, bb, 0);
      end

      // Zero-length requests are rejected with an err pulse the following cycle.
      s_len_i = 12'd5;
      t_len_i = 12'd0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("err_tlen", sample(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      @(negedge clk);
      check("err_clear", sample(), zero);
      s_len_i = 12'd0;
      t_len_i = 12'd3;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("err_slen", sample(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));

      // Abort beats start in IDLE.
      s_len_i = 12'd4;
      t_len_i = 12'd2;
      start_i = 1'b1;
      abort_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      check("abort_start", sample(), zero);

      // Abort in STREAM_T cycle 2, then restart straight away.
      run_pair("abort_run", 5, 4, 0, 10);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_idle", sample(), zero);
      run_pair("after_abort", 5, 4, 1, 0);

      // Asynchronous reset mid LOAD_S.
      run_pair("rst_run", 8, 3, 0, 3);
      #3;
      reset_i = 1'b1;
      #1;
      check("rst_async", sample(), zero);
      @(negedge clk);
      check("rst_hold", sample(), zero);
      check_stall("rst_stall", 0);
      reset_i = 1'b0;
      run_pair("after_rst", 7, 2, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
